// File: rtl/pid_pkg.sv
// Shared types and width helpers for the PID speed-loop controller.
package pid_pkg;

    // Controller sequencing: one product per MUL_* state, then scale/saturate in SUM.
    typedef enum logic [2:0] {
        IDLE,
        MUL_P,
        MUL_I,
        MUL_D,
        SUM
    } state_t;

    // Width of e - e_prev (one extra bit so the difference never wraps).
    function automatic int diff_w(input int data_w);
        return data_w + 1;
    endfunction

    // Width of one signed product: widest operand (the integrator) times a zero-extended gain.
    function automatic int prod_w(input int acc_w, input int gain_w);
        return acc_w + gain_w + 1;
    endfunction

    // Width of the three-term sum: one growth bit over a single product.
    function automatic int sum_w(input int acc_w, input int gain_w);
        return acc_w + gain_w + 2;
    endfunction

endpackage

// File: rtl/pid_if.sv
// Sample/result interface between the speed-error source and the PID controller.
interface pid_if #(
    parameter int DATA_W = 8,
    parameter int GAIN_W = 8,
    parameter int OUT_W  = 8
);
    logic                     sample_valid;
    logic signed [DATA_W-1:0] error;
    logic        [GAIN_W-1:0] kp;
    logic        [GAIN_W-1:0] ki;
    logic        [GAIN_W-1:0] kd;
    logic                     clear_int;
    logic                     busy;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  delta;
    logic                     sat;
    logic                     overrun;

    modport master (
        output sample_valid, error, kp, ki, kd, clear_int,
        input  busy, out_valid, delta, sat, overrun
    );

    modport slave (
        input  sample_valid, error, kp, ki, kd, clear_int,
        output busy, out_valid, delta, sat, overrun
    );
endinterface

// File: rtl/pid_sat.sv
// Generic signed saturator; limits default to the full OUT_W range but can be narrowed.
module pid_sat #(
    parameter int     IN_W  = 16,
    parameter int     OUT_W = 8,
    parameter longint MAX_V = (64'sd1 <<< (OUT_W - 1)) - 64'sd1,
    parameter longint MIN_V = -(64'sd1 <<< (OUT_W - 1))
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
    localparam logic signed [IN_W-1:0] MAX_I = IN_W'(MAX_V);
    localparam logic signed [IN_W-1:0] MIN_I = IN_W'(MIN_V);

    // Clip to [MIN_V, MAX_V] and flag when clipping happened.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block leaves it unassigned (which would infer a latch).
        dout = OUT_W'(din);
        sat  = 1'b0;
        if (din > MAX_I) begin
            dout = OUT_W'(MAX_V);
            sat  = 1'b1;
        end else if (din < MIN_I) begin
            dout = OUT_W'(MIN_V);
            sat  = 1'b1;
        end
    end
endmodule

// File: rtl/pid_ctrl.sv
// Time-shared fixed-point PID: delta = Kp*e + Ki*sum(e) + Kd*(e - e_prev), one multiplier.
module pid_ctrl
    import pid_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAIN_W  = 8,
    parameter int FRAC_W  = 4,
    parameter int OUT_W   = 8,
    parameter int ACC_W   = 16,
    parameter int INT_LIM = 1000
) (
    input  logic clk,
    input  logic rst,
    pid_if.slave bus
);
    localparam int D_W = diff_w(DATA_W);
    localparam int P_W = prod_w(ACC_W, GAIN_W);
    localparam int S_W = sum_w(ACC_W, GAIN_W);

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] e_prev;
    logic signed [OUT_W-1:0]  delta_r;
    logic                     sat_r;
    logic                     out_valid_r;
    logic                     overrun_r;

    // Operands frozen at accept so a clear_int during the computation cannot disturb it.
    logic signed [DATA_W-1:0] e_op;
    logic signed [D_W-1:0]    d_op;
    logic signed [ACC_W-1:0]  acc_op;
    logic        [GAIN_W-1:0] kp_r, ki_r, kd_r;
    logic signed [S_W-1:0]    sum;

    logic                     accept;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [DATA_W-1:0] e_prev_base;
    logic signed [ACC_W:0]    acc_raw;
    logic signed [ACC_W-1:0]  acc_clamped;
    logic                     int_sat_unused;
    logic                     acc_hold;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [D_W-1:0]    d_next;
    logic signed [ACC_W-1:0]  mul_a;
    logic        [GAIN_W-1:0] mul_g;
    logic signed [P_W-1:0]    prod;
    logic signed [S_W-1:0]    prod_ext;
    logic signed [S_W-1:0]    scaled;
    logic signed [OUT_W-1:0]  delta_sat;
    logic                     delta_is_sat;

    assign accept = (state == IDLE) && bus.sample_valid;

    // Accept-time integrator and difference: clear first, then add, clamp, or hold for anti-windup.
    always_comb begin
        acc_base    = bus.clear_int ? '0 : acc;
        e_prev_base = bus.clear_int ? '0 : e_prev;
        acc_raw     = {acc_base[ACC_W-1], acc_base}
                    + {{(ACC_W + 1 - DATA_W){bus.error[DATA_W-1]}}, bus.error};
        d_next      = {bus.error[DATA_W-1], bus.error} - {e_prev_base[DATA_W-1], e_prev_base};
        acc_hold    = sat_r && (bus.error[DATA_W-1] == delta_r[OUT_W-1]);
        acc_next    = acc_hold ? acc_base : acc_clamped;
    end

    pid_sat #(
        .IN_W  (ACC_W + 1),
        .OUT_W (ACC_W),
        .MAX_V (INT_LIM),
        .MIN_V (-INT_LIM)
    ) u_int_clamp (
        .din  (acc_raw),
        .dout (acc_clamped),
        .sat  (int_sat_unused)
    );

    // Operand mux feeding the single signed multiplier; gains are zero-extended.
    always_comb begin
        mul_a = '0;
        mul_g = '0;
        case (state)
            MUL_P: begin
                mul_a = {{(ACC_W - DATA_W){e_op[DATA_W-1]}}, e_op};
                mul_g = kp_r;
            end
            MUL_I: begin
                mul_a = acc_op;
                mul_g = ki_r;
            end
            MUL_D: begin
                mul_a = {{(ACC_W - D_W){d_op[D_W-1]}}, d_op};
                mul_g = kd_r;
            end
            default: ;
        endcase
        prod     = $signed({{(P_W - ACC_W){mul_a[ACC_W-1]}}, mul_a})
                 * $signed({{(P_W - GAIN_W){1'b0}}, mul_g});
        prod_ext = {prod[P_W-1], prod};
        scaled   = sum >>> FRAC_W;
    end

    pid_sat #(
        .IN_W  (S_W),
        .OUT_W (OUT_W)
    ) u_out_clamp (
        .din  (scaled),
        .dout (delta_sat),
        .sat  (delta_is_sat)
    );

    // Control FSM, stored controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            e_prev      <= '0;
            delta_r     <= '0;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
            out_valid_r <= 1'b0;
            if (bus.clear_int) begin
                acc    <= '0;
                e_prev <= '0;
            end
            if (bus.sample_valid && (state != IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        acc    <= acc_next;
                        e_prev <= bus.error;
                        state  <= MUL_P;
                    end
                end
                MUL_P: state <= MUL_I;
                MUL_I: state <= MUL_D;
                MUL_D: state <= SUM;
                SUM: begin
                    delta_r     <= delta_sat;
                    sat_r       <= delta_is_sat;
                    out_valid_r <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture at accept and product accumulation.
    // NOTE: pure datapath registers carry no reset; they are always written before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            e_op   <= bus.error;
            d_op   <= d_next;
            acc_op <= acc_next;
            kp_r   <= bus.kp;
            ki_r   <= bus.ki;
            kd_r   <= bus.kd;
        end
        if (state == MUL_P) begin
            sum <= prod_ext;
        end else if ((state == MUL_I) || (state == MUL_D)) begin
            sum <= sum + prod_ext;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.delta     = delta_r;
    assign bus.sat       = sat_r;
    assign bus.overrun   = overrun_r;
endmodule
